seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
//   - Sequences one shared BCD-to-7-segment decoder across NUM_DIGITS digits.
//   - Drives the decoder's 4-bit number input and the active-low digit anodes.
//   - Inserts a dark gap between digits to prevent ghosting.
//   - Double-buffers digit values so a displayed frame never tears.

---
 rtl/seven_seg_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits with a double-buffered frame.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned PRESCALE   = 100000,
    parameter int unsigned GAP_CYC    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
    localparam int unsigned CNT_MAX = (PRESCALE > GAP_CYC) ? PRESCALE : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_ON   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_W-1:0]       pending_q, pending_d;
    logic [DATA_W-1:0]       active_q, active_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [3:0]              sel_digit_c;
    logic                    lit_c;

    // Sequencing: counter is shared by the dark gap and the lit slot.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        active_d     = active_q;
        pending_d    = load ? digits_in : pending_q;
        frame_tick_d = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = ST_GAP;
                    cnt_d    = '0;
                    idx_d    = '0;
                    active_d = pending_q;
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (cnt_q == CNT_W'(PRESCALE - 1)) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_d        = '0;
                            frame_tick_d = 1'b1;
                            active_d     = load ? digits_in : pending_q;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  zero_above_c;

    // A digit is blank when it and every more significant digit of the frame are zero.
    always_comb begin
        blank_c      = '0;
        zero_above_c = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            zero_above_c = zero_above_c && (active_d[4*k +: 4] == 4'd0);
            blank_c[k]   = zero_above_c;
        end
    end
`endif

    // Registered outputs derived from the next state so they align with it.
    always_comb begin
        sel_digit_c = active_d[4*int'(idx_d) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lit_c = digit_mask[idx_d] && !blank_c[idx_d];
`else
        lit_c = digit_mask[idx_d];
`endif
        an_n_d      = '1;
        bcd_d       = 4'd0;
        digit_idx_d = idx_d;
        unique case (state_d)
            ST_GAP: bcd_d = sel_digit_c;
            ST_ON: begin
                bcd_d = sel_digit_c;
                if (lit_c) begin
                    an_n_d[idx_d] = 1'b0;
                end
            end
            default: bcd_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            active_q     <= '0;
            bcd_q        <= 4'd0;
            an_n_q       <= '1;
            digit_idx_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            bcd_q        <= bcd_d;
            an_n_q       <= an_n_d;
            digit_idx_q  <= digit_idx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign an_n       = an_n_q;
    assign digit_idx  = digit_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: per-cycle reference model feeding a scoreboard queue.
module tb_seven_seg_scan_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned P     = 4;
    localparam int unsigned G     = 2;
    localparam int unsigned SLOT  = G + P;
    localparam int unsigned FRAME = N * SLOT;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  digit_mask;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int tests;
    int fails;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .GAP_CYC(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .digit_mask (digit_mask),
        .bcd_out    (bcd_out),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit blanked(input logic [15:0] act, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
        return (slot > 0) && ((act >> (4 * slot)) == 16'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: position in the frame is just elapsed cycles since the scan started.
    initial begin : model
        int unsigned t;
        bit          running;
        logic [15:0] pend;
        logic [15:0] act;
        exp_t        e;
        int          slot;
        int          phase;
        t = 0; running = 0; pend = '0; act = '0;
        forever begin
            @(posedge clk);
            e = '{an: 4'hF, bcd: 4'h0, idx: 2'd0, tick: 1'b0};
            if (!rst_n) begin
                running = 0; t = 0; pend = '0; act = '0;
            end else if (!en) begin
                running = 0; t = 0;
                if (load) pend = digits_in;
            end else begin
                if (!running) begin
                    running = 1; t = 0; act = pend;
                end else begin
                    t = t + 1;
                    if (t == FRAME) begin
                        t = 0;
                        e.tick = 1'b1;
                        act = load ? digits_in : pend;
                    end
                end
                if (load) pend = digits_in;
                slot  = int'(t / SLOT);
                phase = int'(t % SLOT);
                e.idx = 2'(slot);
                e.bcd = 4'(act >> (4 * slot));
                if (phase >= int'(G) && digit_mask[slot] && !blanked(act, slot))
                    e.an = ~(4'(1) << slot);
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty at %0t: DUT an_n=%b with no expected entry", $time, an_n);
            end else begin
                e = exp_q.pop_front();
                if ({an_n, bcd_out, digit_idx, frame_tick} !== e) begin
                    fails++;
                    $display("FAIL scoreboard at %0t: got an_n=%b bcd=%h idx=%0d tick=%b, want an_n=%b bcd=%h idx=%0d tick=%b",
                             $time, an_n, bcd_out, digit_idx, frame_tick, e.an, e.bcd, e.idx, e.tick);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        load = 1'b1;
        digits_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Bounded wait for a given digit to be lit; a timeout counts as a failure.
    task automatic wait_lit(input int k);
        int n;
        n = 0;
        while (!(digit_idx == 2'(k) && an_n != 4'hF) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL wait_lit digit %0d: timed out, an_n=%b idx=%0d", k, an_n, digit_idx);
        end
    endtask

    initial begin : stim
        tests = 0; fails = 0;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0; digit_mask = 4'hF;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // Basic scan of 4321 for two frames.
        do_load(16'h4321);
        en = 1'b1;
        cyc(2 * FRAME);

        // Pending write during slot 1 must not reach the current frame.
        wait_lit(1);
        do_load(16'h9999);
        cyc(2 * FRAME);

        // Masked slots stay dark.
        digit_mask = 4'b1010;
        cyc(FRAME + 5);
        digit_mask = 4'hF;
        cyc(FRAME);

        // Disable during digit 2 lit, then restart from digit 0.
        wait_lit(2);
        cyc(1);
        en = 1'b0;
        cyc(4);
        en = 1'b1;
        cyc(FRAME + 3);

        // Leading zero frame, plus non-BCD values.
        do_load(16'h0050);
        cyc(2 * FRAME + 4);
        do_load(16'hAF0C);
        cyc(2 * FRAME);

        // Random loads, mask changes and short enable drops.
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 9) == 0);
            digits_in = 16'($urandom);
            if ($urandom_range(0, 29) == 0) digit_mask = 4'($urandom);
            en = ($urandom_range(0, 149) != 0);
        end
        load = 1'b0;
        en = 1'b1;
        digit_mask = 4'hF;
        do_load(16'h8765);
        cyc(FRAME);

        // Asynchronous reset while a digit is lit.
        wait_lit(1);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (an_n !== 4'hF || bcd_out !== 4'h0 || digit_idx !== 2'd0 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got an_n=%b bcd=%h idx=%0d tick=%b, want 1111 0 0 0",
                     an_n, bcd_out, digit_idx, frame_tick);
        end
        cyc(3);
        rst_n = 1'b1;
        cyc(FRAME + 4);
        en = 1'b0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
